// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue/collect controller between execute and the multicycle mult/div units.
// Optional build macro MD_DIV_ZERO_BYPASS_EN: a divide by zero accepted in IDLE skips the divider.
module md_issue_ctrl #(
    parameter int WIDTH    = 32,
    parameter int TAG_W    = 5,
    parameter int MIN_WAIT = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic             req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             req_ready,
    output logic             stall,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    output logic             div_start,
    input  logic [WIDTH-1:0] div_out,
    input  logic             div_rdy,
    input  logic             div_ovf,
    output logic [WIDTH-1:0] mult_a,
    output logic [WIDTH-1:0] mult_b,
    output logic             mult_start,
    input  logic [WIDTH-1:0] mult_out,
    input  logic             mult_rdy,
    input  logic             mult_ovf,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_exc,
    output logic [TAG_W-1:0] resp_tag
);

    localparam int CNT_W = (MIN_WAIT < 1) ? 1 : $clog2(MIN_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           nextState_s;
    logic             opDiv_r;
    logic [WIDTH-1:0] opA_r;
    logic [WIDTH-1:0] opB_r;
    logic [TAG_W-1:0] opTag_r;
    logic [CNT_W-1:0] waitCnt_r;
    logic             divStart_r;
    logic             multStart_r;
    logic             respValid_r;
    logic             respExc_r;
    logic [WIDTH-1:0] respData_r;
    logic [TAG_W-1:0] respTag_r;

    logic             accept_s;
    logic             bypass_s;
    logic             launch_s;
    logic             capture_s;
    logic             selRdy_s;
    logic             selOvf_s;
    logic [WIDTH-1:0] selOut_s;

    assign req_ready    = (state_r == IDLE) | ((state_r == HOLD) & resp_ready);
    assign stall        = (state_r != IDLE);
    assign accept_s     = req_valid & req_ready;

    assign div_dividend = opA_r;
    assign div_divisor  = opB_r;
    assign mult_a       = opA_r;
    assign mult_b       = opB_r;
    assign div_start    = divStart_r;
    assign mult_start   = multStart_r;
    assign resp_valid   = respValid_r;
    assign resp_data    = respData_r;
    assign resp_exc     = respExc_r;
    assign resp_tag     = respTag_r;

`ifdef MD_DIV_ZERO_BYPASS_EN
    assign bypass_s = accept_s & (state_r == IDLE) & req_op & (req_b == {WIDTH{1'b0}});
`else
    assign bypass_s = 1'b0;
`endif
    assign launch_s = accept_s & ~bypass_s;

    // Only the unit that was started is listened to; the other unit's rdy is noise.
    always_comb begin
        selRdy_s = 1'b0;
        selOvf_s = 1'b0;
        selOut_s = {WIDTH{1'b0}};
        if (opDiv_r) begin
            selRdy_s = div_rdy;
            selOvf_s = div_ovf;
            selOut_s = div_out;
        end else begin
            selRdy_s = mult_rdy;
            selOvf_s = mult_ovf;
            selOut_s = mult_out;
        end
    end

    // A stale rdy left over from the previous operation is masked until the counter drains.
    assign capture_s = (state_r == WAIT) & (waitCnt_r == {CNT_W{1'b0}}) & selRdy_s;

    // Next-state logic
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (bypass_s) begin
                    nextState_s = HOLD;
                end else if (launch_s) begin
                    nextState_s = LAUNCH;
                end else begin
                    nextState_s = IDLE;
                end
            end
            LAUNCH: nextState_s = WAIT;
            WAIT: begin
                if (capture_s) begin
                    nextState_s = HOLD;
                end else begin
                    nextState_s = WAIT;
                end
            end
            HOLD: begin
                if (launch_s) begin
                    nextState_s = LAUNCH;
                end else if (resp_ready) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = HOLD;
                end
            end
            default: nextState_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Request latch, start pulses and rdy-mask counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            opDiv_r     <= 1'b0;
            opA_r       <= {WIDTH{1'b0}};
            opB_r       <= {WIDTH{1'b0}};
            opTag_r     <= {TAG_W{1'b0}};
            divStart_r  <= 1'b0;
            multStart_r <= 1'b0;
            waitCnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                opDiv_r <= req_op;
                opA_r   <= req_a;
                opB_r   <= req_b;
                opTag_r <= req_tag;
            end
            divStart_r  <= launch_s & req_op;
            multStart_r <= launch_s & ~req_op;
            if (launch_s) begin
                waitCnt_r <= CNT_W'(MIN_WAIT);
            end else if (waitCnt_r != {CNT_W{1'b0}}) begin
                waitCnt_r <= waitCnt_r - CNT_W'(1);
            end
        end
    end

    // Result capture; held untouched through HOLD until the next capture or bypass
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            respValid_r <= 1'b0;
            respData_r  <= {WIDTH{1'b0}};
            respExc_r   <= 1'b0;
            respTag_r   <= {TAG_W{1'b0}};
        end else begin
            respValid_r <= (nextState_s == HOLD);
            if (capture_s) begin
                respData_r <= selOut_s;
                respExc_r  <= selOvf_s;
                respTag_r  <= opTag_r;
            end else if (bypass_s) begin
                respData_r <= {WIDTH{1'b0}};
                respExc_r  <= 1'b1;
                respTag_r  <= req_tag;
            end
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: randomized scoreboard bench for md_issue_ctrl with behavioural mult/div units.
// Honours MD_DIV_ZERO_BYPASS_EN the same way the design does.
module tb_md_issue_ctrl;

    localparam int WIDTH    = 32;
    localparam int TAG_W    = 5;
    localparam int MIN_WAIT = 2;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             req_valid, req_op, req_ready, stall;
    logic [WIDTH-1:0] req_a, req_b;
    logic [TAG_W-1:0] req_tag;
    logic [WIDTH-1:0] div_dividend, div_divisor, div_out;
    logic             div_start, div_rdy, div_ovf;
    logic [WIDTH-1:0] mult_a, mult_b, mult_out;
    logic             mult_start, mult_rdy, mult_ovf;
    logic             resp_valid, resp_ready, resp_exc;
    logic [WIDTH-1:0] resp_data;
    logic [TAG_W-1:0] resp_tag;

    always #5 clock = ~clock;

    md_issue_ctrl #(.WIDTH(WIDTH), .TAG_W(TAG_W), .MIN_WAIT(MIN_WAIT)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_tag(req_tag), .req_ready(req_ready), .stall(stall),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_start(div_start),
        .div_out(div_out), .div_rdy(div_rdy), .div_ovf(div_ovf),
        .mult_a(mult_a), .mult_b(mult_b), .mult_start(mult_start),
        .mult_out(mult_out), .mult_rdy(mult_rdy), .mult_ovf(mult_ovf),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_exc(resp_exc), .resp_tag(resp_tag)
    );

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             exc;
        logic [TAG_W-1:0] tag;
    } resp_t;

    resp_t            respQ[$];
    logic             startQ[$];
    int               passCnt  = 0;
    int               totalCnt = 0;
    logic [WIDTH-1:0] curA = '0;
    logic [WIDTH-1:0] curB = '0;
    int               rrMode = 0;
    logic             forceStale = 1'b0;

    // unit model state, index 0 = multiplier, 1 = divider
    logic uBusy[2], uSticky[2], uStale[2];
    int   uK[2], uLat[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        totalCnt++;
        $display("FAIL %s: got an expired bound or unexpected event, required normal progress", name);
    endtask

    // Architectural result of a mult/div op: signed, low WIDTH bits; exc on overflow or /0.
    function automatic resp_t refModel(input logic op, input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
        resp_t  r;
        longint p;
        int     qa, qb;
        r.tag = tag;
        qa = $signed(a);
        qb = $signed(b);
        if (!op) begin
            p      = longint'(qa) * longint'(qb);
            r.data = WIDTH'(p);
            r.exc  = (p != longint'(int'(p)));
        end else if (qb == 0) begin
            r.data = '0;
            r.exc  = 1'b1;
        end else begin
            r.data = WIDTH'(qa / qb);
            r.exc  = 1'b0;
        end
        return r;
    endfunction

    // Per-cycle update of resp_ready and the two behavioural units (called #1 after each edge).
    task automatic stepCycle();
        logic             st, rdy, ov;
        logic [WIDTH-1:0] o;
        resp_t            r;
        case (rrMode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = 1'($urandom % 2);
            default: resp_ready = 1'b0;
        endcase
        for (int u = 0; u < 2; u++) begin
            if (u == 1) begin st = div_start;  rdy = div_rdy;  o = div_out;  ov = div_ovf;  end
            else        begin st = mult_start; rdy = mult_rdy; o = mult_out; ov = mult_ovf; end
            if (st) begin
                uBusy[u]   = 1'b1;
                uK[u]      = 0;
                uLat[u]    = $urandom_range(0, 3);
                uSticky[u] = 1'($urandom % 2);
                uStale[u]  = forceStale | 1'($urandom % 2);
            end else if (uBusy[u]) begin
                uK[u]++;
            end
            if (uBusy[u]) begin
                if (uK[u] < MIN_WAIT) begin
                    if (uStale[u]) begin rdy = 1'b1; o = $urandom; ov = 1'($urandom % 2); end
                    else rdy = 1'b0;
                end else if (uK[u] < MIN_WAIT + uLat[u]) begin
                    rdy = 1'b0;
                end else begin
                    if (u == 1) r = refModel(1'b1, div_dividend, div_divisor, '0);
                    else        r = refModel(1'b0, mult_a, mult_b, '0);
                    rdy = 1'b1; o = r.data; ov = r.exc; uBusy[u] = 1'b0;
                end
            end else if (!uSticky[u]) begin
                rdy = ($urandom % 4 == 0);
                if (rdy) begin o = $urandom; ov = 1'($urandom % 2); end
            end
            if (u == 1) begin div_rdy = rdy;  div_out = o;  div_ovf = ov;  end
            else        begin mult_rdy = rdy; mult_out = o; mult_ovf = ov; end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        stepCycle();
    endtask

    // Present one request until accepted; then confirm the launch in the following cycle.
    task automatic drive(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [TAG_W-1:0] tag);
        logic acc = 1'b0;
        logic byp = 1'b0;
        int   n   = 0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        while (!acc && n < 200) begin
            @(negedge clock);
            acc = req_ready;
            if (acc) begin
`ifdef MD_DIV_ZERO_BYPASS_EN
                byp = op && (b == '0) && !resp_valid;
`endif
                respQ.push_back(refModel(op, a, b, tag));
                if (!byp) startQ.push_back(op);
            end
            tick();
            n++;
        end
        req_valid = 1'b0;
        if (!acc) begin
            fail("accept_timeout");
        end else begin
            curA = a;
            curB = b;
            @(negedge clock);
            if (byp) check("bypass_resp_valid", 64'({resp_valid, div_start}), 64'(2'b10));
            else     check("start_after_accept", 64'({div_start, mult_start}), op ? 64'(2'b10) : 64'(2'b01));
            tick();
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd();
        if ($urandom % 2) return WIDTH'($urandom_range(0, 200)) - WIDTH'(100);
        else return $urandom;
    endfunction

    // Monitor: pops the scoreboard on every handshake and watches hold/launch invariants.
    resp_t prevResp;
    logic  prevWait  = 1'b0;
    logic  prevStart = 1'b0;
    always @(negedge clock) begin
        resp_t e;
        logic  u;
        if (!reset_n) begin
            prevWait  = 1'b0;
            prevStart = 1'b0;
        end else begin
            check("div_operands", {div_dividend, div_divisor}, {curA, curB});
            check("mult_operands", {mult_a, mult_b}, {curA, curB});
            if (prevWait) begin
                check("hold_valid", 64'(resp_valid), 64'(1'b1));
                check("hold_stable", 64'({resp_data, resp_exc, resp_tag}), 64'(prevResp));
            end
            if (resp_valid) check("hold_stall_ready", 64'({stall, req_ready}), 64'({1'b1, resp_ready}));
            if (div_start || mult_start) begin
                check("start_single_cycle", 64'({div_start & mult_start, prevStart}), 64'(0));
                if (startQ.size() == 0) fail("unexpected_start");
                else begin
                    u = startQ.pop_front();
                    check("start_unit", 64'(div_start), 64'(u));
                end
            end
            if (resp_valid && resp_ready) begin
                if (respQ.size() == 0) fail("unexpected_response");
                else begin
                    e = respQ.pop_front();
                    check("response", 64'({resp_data, resp_exc, resp_tag}), 64'(e));
                end
            end
            prevWait  = resp_valid && !resp_ready;
            prevResp  = {resp_data, resp_exc, resp_tag};
            prevStart = div_start | mult_start;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic             op;
        logic [WIDTH-1:0] a, b;
        int               n;
        for (int u = 0; u < 2; u++) begin
            uBusy[u] = 1'b0; uSticky[u] = 1'b0; uStale[u] = 1'b0; uK[u] = 0; uLat[u] = 0;
        end
        reset_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; req_tag = '0;
        resp_ready = 1'b0; div_out = '0; div_rdy = 1'b0; div_ovf = 1'b0;
        mult_out = '0; mult_rdy = 1'b0; mult_ovf = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_ctrl", 64'({resp_valid, stall, div_start, mult_start, req_ready}), 64'(5'b00001));
        check("reset_resp", 64'({resp_data, resp_exc, resp_tag}), 64'(0));
        check("reset_operands", {div_dividend, mult_b}, 64'(0));
        reset_n = 1'b1;

        // directed cases with stale rdy forced through the masking window
        rrMode = 0;
        forceStale = 1'b1;
        drive(1'b1, 32'd100, 32'd7, 5'd3);
        drive(1'b1, 32'hFFFFFF9C, 32'd7, 5'd1);
        drive(1'b0, 32'd6, 32'd7, 5'd9);
        drive(1'b1, 32'd8, 32'd0, 5'd4);
        drive(1'b0, 32'h00010000, 32'h00010000, 5'd5);
        repeat (10) tick();
        check("idle_after_directed", 64'({stall, req_ready, resp_valid}), 64'(3'b010));
        check("directed_drained", 64'(respQ.size()), 64'(0));

        // backpressure in HOLD, then back-to-back issue
        rrMode = 2;
        drive(1'b1, 32'd50, 32'd5, 5'd7);
        n = 0;
        while (!resp_valid && n < 50) begin tick(); n++; end
        if (!resp_valid) fail("hold_timeout");
        repeat (5) begin
            tick();
            check("backpressure_hold", 64'({stall, resp_valid, resp_data, resp_tag}),
                  64'({1'b1, 1'b1, 32'd10, 5'd7}));
        end
        rrMode = 0;
        resp_ready = 1'b1;
        drive(1'b0, 32'd3, 32'd4, 5'd2);

        // randomized traffic
        rrMode = 1;
        forceStale = 1'b0;
        repeat (150) begin
            op = 1'($urandom % 2);
            a  = rnd();
            b  = rnd();
            if (op && ($urandom % 8 == 0)) b = '0;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
            drive(op, a, b, TAG_W'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        rrMode = 0;
        n = 0;
        while (respQ.size() != 0 && n < 100) begin tick(); n++; end
        check("random_drained", 64'(respQ.size()), 64'(0));

        // reset while the divider is in flight
        drive(1'b1, 32'd1000, 32'd10, 5'd6);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_mid_wait", 64'({resp_valid, stall, req_ready, div_start}), 64'(4'b0010));
        check("reset_mid_operands", {div_dividend, div_divisor}, 64'(0));
        respQ.delete();
        startQ.delete();
        curA = '0;
        curB = '0;
        tick();
        reset_n = 1'b1;
        repeat (8) begin
            tick();
            check("aborted_not_reported", 64'({resp_valid, stall}), 64'(0));
        end
        drive(1'b0, 32'hFFFFFFFD, 32'd5, 5'd8);
        n = 0;
        while (respQ.size() != 0 && n < 50) begin tick(); n++; end
        check("final_drained", 64'(respQ.size()), 64'(0));

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Issue/collect controller between the execute stage and the multicycle divider and multiplier units.
- Latches one mult/div request and holds its operands stable on the unit inputs for the whole operation; the divider's sign correction reads its operands at completion.
- Pulses the unit's start and waits for its ready.
- Captures result and exception, then presents them to writeback with a valid/ready handshake. Drives the pipeline stall while busy.

Parameters:
- WIDTH, 32, operand/result width.
- TAG_W, 5, destination register tag width.
- MIN_WAIT, 2, cycles after the start pulse during which unit rdy is ignored; blocks stale rdy from a previous operation.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a mult/div op
- req_op  in  1  0 = multiply, 1 = divide
- req_a  in  WIDTH  multiplicand / dividend
- req_b  in  WIDTH  multiplier / divisor
- req_tag  in  TAG_W  destination register
- req_ready  out  1  request accepted this cycle when req_valid is also high
- stall  out  1  high whenever the state is not IDLE
- div_dividend, div_divisor  out  WIDTH  held operands to divider
- div_start  out  1  one-cycle start to divider
- div_out  in  WIDTH  divider quotient
- div_rdy, div_ovf  in  1  divider done / divide-by-zero
- mult_a, mult_b  out  WIDTH  held operands to multiplier
- mult_start  out  1  one-cycle start to multiplier
- mult_out  in  WIDTH  product
- mult_rdy, mult_ovf  in  1  multiplier done / overflow
- resp_valid  out  1  result available
- resp_ready  in  1  writeback accepts result
- resp_data  out  WIDTH  result
- resp_exc  out  1  overflow / divide-by-zero flag
- resp_tag  out  TAG_W  destination register of the result

Behaviour:
- Reset: async, state IDLE. All registered outputs are 0: operands, tag, resp_data, resp_exc, resp_valid, both start signals, wait counter. Reset mid-operation aborts; the in-flight unit result is discarded and never reported.
- States: IDLE, LAUNCH, WAIT, HOLD.
- req_ready = (state==IDLE) | (state==HOLD & resp_ready).
- IDLE: on req_valid, at the clock edge latch req_op, req_a, req_b and req_tag, then go to LAUNCH.
- LAUNCH: exactly one cycle. The start of the selected unit is high (registered output); the other start stays low. Wait counter is loaded with MIN_WAIT. Go to WAIT.
- WAIT: counter decrements to 0. While the counter is nonzero, rdy is ignored. When the counter is 0 and the selected unit's rdy is high, latch its out into resp_data, its ovf into resp_exc, and the latched tag into resp_tag. Go to HOLD.
- The unselected unit's rdy is always ignored.
- HOLD: resp_valid=1. resp_data, resp_exc and resp_tag are stable until the handshake.
- In HOLD, resp_ready & ~req_valid: go to IDLE; resp_valid falls next cycle.
- In HOLD, resp_ready & req_valid: new request latched, go to LAUNCH (back-to-back issue, no IDLE bubble).
- Operand outputs to both units are driven from the latched registers in every state. They change only when a request is accepted.
- Latency: accept at edge N, start high in cycle N+1. Earliest capture is at the edge ending cycle N+1+MIN_WAIT. resp_valid is high from that edge to the handshake.
- stall = (state != IDLE).

Optional Feature:
- Macro: MD_DIV_ZERO_BYPASS_EN.
- Defined: in IDLE, a divide with req_b==0 goes directly to HOLD at the accepting edge. It produces resp_data=0, resp_exc=1 and the latched tag. div_start is never pulsed.
- Not defined: a divide by zero takes the normal LAUNCH/WAIT path. The result is whatever the divider reports on div_out and div_ovf (expected 0 and 1).

Test Plan:
- Divide req_a=100, req_b=7, tag=3, resp_ready=1 -> one div_start pulse; resp_data=14, resp_exc=0, resp_tag=3; div operands stay 100/7 until capture.
- Divide req_a=-100, req_b=7 -> resp_data=-14 (0xFFFFFFF2); div_dividend held at 0xFFFFFF9C throughout WAIT.
- Multiply 6*7, tag=9 -> mult_start pulses once, div_start stays 0, resp_data=42; a div_rdy pulse injected during WAIT is ignored.
- Divide 8/0 -> resp_data=0, resp_exc=1. With MD_DIV_ZERO_BYPASS_EN: resp_valid the cycle after accept and no div_start.
- Stale rdy: div_rdy held high from the previous op through LAUNCH and the first MIN_WAIT cycles -> no capture until the counter reaches 0.
- Backpressure and reset: resp_ready=0 for 5 cycles in HOLD -> data and tag stable, stall=1. Then resp_ready=1 with req_valid=1 -> LAUNCH next cycle. reset_n low mid-WAIT -> IDLE, resp_valid=0, stall=0 immediately.
